// File: rtl/cic_pkg.sv
// Shared CIC constants so the integrator and comb halves are built with identical widths.
// The full-precision width is IW + N*clog2(R), which makes the comb wrap-cancellation exact.
package cic_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int CIC_IW = 2;
    localparam int CIC_N  = 3;
    localparam int CIC_R  = 64;
    localparam int CIC_OW = CIC_IW + CIC_N * clog2(CIC_R);

endpackage

// File: rtl/cic_integrator_stage.sv
// One CIC integrator: a wrapping accumulator that adds its operand on every enabled cycle.
// The operand is the previous stage's registered value, so the cascade is pipelined.
module cic_integrator_stage #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] operand,
    output logic [W-1:0] acc
);

    // NOTE: state registers use non-blocking assignments so every stage samples
    // the pre-edge value of its neighbour, which is what gives the pipelined sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + operand;  // modulo 2^W on purpose; the combs cancel the wrap
        end
    end

endmodule

// File: rtl/cic_integrator_decimator.sv
// Integrator half of the CIC decimator: N cascaded integrators at the sample rate plus
// a decimate-by-R strobe that hands the last integrator's value to the comb chain.
module cic_integrator_decimator
    import cic_pkg::*;
#(
    parameter int IW = CIC_IW,
    parameter int N  = CIC_N,
    parameter int R  = CIC_R,
    parameter int OW = CIC_OW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [IW-1:0] i_data,
    input  logic          i_ready,
    output logic [OW-1:0] o_data,
    output logic          o_ready
);

    localparam int CW = clog2(R);
    localparam logic [CW-1:0] LAST_CNT = CW'(R - 1);

    logic [OW-1:0] operand [N];
    logic [OW-1:0] acc     [N];
    logic [CW-1:0] dec_cnt;
    logic          frame_end;

    assign operand[0] = OW'($signed(i_data));

    for (genvar k = 0; k < N; k++) begin : g_stage
        if (k > 0) begin : g_chain
            assign operand[k] = acc[k-1];
        end

        cic_integrator_stage #(
            .W (OW)
        ) u_stage (
            .clk     (i_clk),
            .rst_n   (i_rst_n),
            .en      (i_ready),
            .operand (operand[k]),
            .acc     (acc[k])
        );
    end

    assign frame_end = (dec_cnt == LAST_CNT);

    // R is a power of two, so the counter wraps R-1 -> 0 without a compare.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dec_cnt <= '0;
            o_data  <= '0;
            o_ready <= 1'b0;
        end else begin
            o_ready <= 1'b0;
            if (i_ready) begin
                dec_cnt <= dec_cnt + CW'(1);
                if (frame_end) begin
                    o_data  <= acc[N-1] + operand[N-1];
                    o_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cic_integrator_decimator.sv
// Self-checking bench: a binomial-convolution reference model of the integrator cascade,
// compared against the DUT every cycle, plus literal strobe values and a comb-chain model.
module tb_cic_integrator_decimator;
    import cic_pkg::*;

    localparam int IW = CIC_IW;
    localparam int N  = CIC_N;
    localparam int R  = CIC_R;
    localparam int OW = CIC_OW;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic [IW-1:0] i_data;
    logic          i_ready;
    logic [OW-1:0] o_data;
    logic          o_ready;

    int n_checks = 0;
    int n_pass   = 0;

    cic_integrator_decimator #(
        .IW (IW),
        .N  (N),
        .R  (R),
        .OW (OW)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_data),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_ready (o_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    // Reference: the last integrator after sample n equals sum_m x[m] * C(n-m, N-1).
    function automatic longint binom(input longint a, input int b);
        longint r;
        r = 1;
        for (int i = 0; i < b; i++) begin
            r = r * (a - i) / (i + 1);
        end
        return r;
    endfunction

    longint        hist [$];
    logic          exp_ready;
    logic [OW-1:0] exp_data;
    logic [OW-1:0] model_q [$];
    logic [OW-1:0] dut_q   [$];

    always @(posedge i_clk) begin
        if (i_rst_n !== 1'b1) begin
            hist.delete();
            exp_ready = 1'b0;
            exp_data  = '0;
        end else begin
            exp_ready = 1'b0;
            if (i_ready === 1'b1) begin
                longint total;
                int     n;
                hist.push_back(longint'($signed(i_data)));
                if (hist.size() % R == 0) begin
                    n     = hist.size() - 1;
                    total = 0;
                    for (int m = 0; m <= n; m++) begin
                        total += hist[m] * binom(longint'(n - m), N - 1);
                    end
                    exp_ready = 1'b1;
                    exp_data  = OW'(total);
                    model_q.push_back(exp_data);
                end
            end
        end
    end

    int cycle       = 0;
    int last_strobe = -1;
    int spacing     = 0;

    always @(posedge i_clk) begin
        #1;
        cycle++;
        check("o_ready", 64'(o_ready), 64'(exp_ready));
        check("o_data", 64'(o_data), 64'(exp_data));
        if (o_ready === 1'b1) begin
            dut_q.push_back(o_data);
            if (spacing != 0 && last_strobe >= 0) begin
                check("strobe_spacing", 64'(cycle - last_strobe), 64'(spacing));
            end
            last_strobe = cycle;
        end
    end

    function automatic logic [63:0] mq(input int idx);
        if (idx < model_q.size()) return 64'(model_q[idx]);
        return '1;
    endfunction

    task automatic start_phase(input int sp);
        model_q.delete();
        dut_q.delete();
        last_strobe = -1;
        spacing     = sp;
    endtask

    task automatic apply_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_ready = 1'b1;
        i_data  = IW'(1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b0;
    endtask

    task automatic feed(input int value, input int gap);
        @(negedge i_clk);
        i_ready = 1'b1;
        i_data  = IW'(value);
        repeat (gap - 1) begin
            @(negedge i_clk);
            i_ready = 1'b0;
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge i_clk);
            i_ready = 1'b0;
        end
    endtask

    // Three-stage differential-delay-1 comb over the DUT strobes; steady state is x*R^N.
    task automatic comb_check(input string name, input logic [OW-1:0] steady);
        logic [OW-1:0] d1, d2, d3, o1, o2, o3;
        d1 = '0; d2 = '0; d3 = '0;
        check({name, "_count"}, 64'(dut_q.size()), 64'(4));
        for (int i = 0; i < dut_q.size(); i++) begin
            o1 = dut_q[i] - d1; d1 = dut_q[i];
            o2 = o1 - d2;       d2 = o1;
            o3 = o2 - d3;       d3 = o2;
            if (i >= 2) check(name, 64'(o3), 64'(steady));
        end
    endtask

    initial begin
        // Reset held with live input: nothing may accumulate or strobe.
        i_rst_n = 1'b0;
        i_ready = 1'b1;
        i_data  = IW'(1);
        repeat (6) @(negedge i_clk);
        check("reset_o_data", 64'(o_data), 64'(0));
        check("reset_o_ready", 64'(o_ready), 64'(0));
        check("reset_no_strobe", 64'(dut_q.size()), 64'(0));
        i_rst_n = 1'b1;
        i_ready = 1'b0;

        // Impulse response.
        start_phase(0);
        feed(1, 1);
        repeat (127) feed(0, 1);
        idle(2);
        check("impulse_s0", mq(0), 64'(1953));
        check("impulse_s1", mq(1), 64'(8001));
        check("impulse_count", 64'(dut_q.size()), 64'(2));

        // DC step, back-to-back samples; third value wraps modulo 2^OW.
        apply_reset();
        start_phase(R);
        repeat (3 * R) feed(1, 1);
        idle(2);
        check("dc_s0", mq(0), 64'(41664));
        check("dc_s1", mq(1), 64'(341376));
        check("dc_s2_wrap", mq(2), 64'(112704));
        check("dc_count", 64'(dut_q.size()), 64'(3));

        // Same DC stimulus, one sample every third cycle.
        apply_reset();
        start_phase(3 * R);
        repeat (3 * R) feed(1, 3);
        idle(2);
        check("gap_s0", mq(0), 64'(41664));
        check("gap_s1", mq(1), 64'(341376));
        check("gap_s2", mq(2), 64'(112704));
        check("gap_count", 64'(dut_q.size()), 64'(3));

        // Reset mid-frame discards the partial frame.
        apply_reset();
        start_phase(0);
        repeat (40) feed(1, 1);
        apply_reset();
        repeat (R - 1) feed(1, 1);
        idle(2);
        check("midrst_no_early", 64'(dut_q.size()), 64'(0));
        feed(1, 1);
        idle(2);
        check("midrst_count", 64'(dut_q.size()), 64'(1));
        check("midrst_s0", mq(0), 64'(41664));

        // Chained into a comb model: +1 -> R^N, -1 -> -R^N.
        apply_reset();
        start_phase(0);
        repeat (4 * R) feed(1, 1);
        idle(2);
        comb_check("comb_pos", OW'(262144));

        apply_reset();
        start_phase(0);
        repeat (4 * R) feed(-1, 1);
        idle(2);
        comb_check("comb_neg", OW'(-262144));

        // Random samples and gaps, with one reset dropped in part way.
        apply_reset();
        start_phase(0);
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) apply_reset();
            feed(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end
        idle(2);
        check("rand_strobe_count", 64'(dut_q.size()), 64'(model_q.size()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
